// File: rtl/mem_stage.sv
// Memory pipeline stage: two-state FSM (IDLE/WAIT) that issues data-memory requests and retires to WB.
// Optional MEM_TIMEOUT_EN adds a WAIT-cycle watchdog that aborts with mem_fault after TIMEOUT_CYCLES.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] data_in,
  input  logic [4:0]  rd_mem,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_wb,
  output logic        misalign,
  output logic        mem_fault,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_n;
  logic        wb_valid_n, misalign_n, mem_fault_n, dmem_we_n;
  logic [31:0] wb_data_n, dmem_addr_n, dmem_wdata_n;
  logic [4:0]  rd_wb_n, rd_lat, rd_lat_n;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  // Request is a pure decode of the state, so reset drops it on the same edge.
  assign stall     = (state == WAIT);
  assign dmem_req  = (state == WAIT);
  assign state_dbg = state;

  always_comb begin
    state_n      = state;
    wb_valid_n   = 1'b0;
    misalign_n   = 1'b0;
    mem_fault_n  = 1'b0;
    wb_data_n    = wb_data;
    rd_wb_n      = rd_wb;
    dmem_addr_n  = dmem_addr;
    dmem_we_n    = dmem_we;
    dmem_wdata_n = dmem_wdata;
    rd_lat_n     = rd_lat;
`ifdef MEM_TIMEOUT_EN
    cnt_n        = cnt;
`endif
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (mem_read || mem_write) begin
            if (mem_addr[1:0] != 2'b00) begin
              wb_valid_n = 1'b1;
              misalign_n = 1'b1;
              wb_data_n  = 32'h0;
              rd_wb_n    = 5'd0;
            end else begin
              // mem_write wins when both are set: the entry is a store.
              state_n      = WAIT;
              dmem_addr_n  = mem_addr;
              dmem_we_n    = mem_write;
              dmem_wdata_n = data_in;
              rd_lat_n     = rd_mem;
`ifdef MEM_TIMEOUT_EN
              cnt_n        = '0;
`endif
            end
          end else begin
            wb_valid_n = 1'b1;
            wb_data_n  = mem_addr;
            rd_wb_n    = rd_mem;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_n    = IDLE;
          wb_valid_n = 1'b1;
          if (dmem_we) begin
            wb_data_n = 32'h0;
            rd_wb_n   = 5'd0;
          end else begin
            wb_data_n = dmem_rdata;
            rd_wb_n   = rd_lat;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n     = IDLE;
          wb_valid_n  = 1'b1;
          mem_fault_n = 1'b1;
          wb_data_n   = 32'h0;
          rd_wb_n     = 5'd0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      wb_valid   <= 1'b0;
      misalign   <= 1'b0;
      wb_data    <= 32'h0;
      rd_wb      <= 5'd0;
      dmem_addr  <= 32'h0;
      dmem_we    <= 1'b0;
      dmem_wdata <= 32'h0;
      rd_lat     <= 5'd0;
    end else begin
      state      <= state_n;
      wb_valid   <= wb_valid_n;
      misalign   <= misalign_n;
      wb_data    <= wb_data_n;
      rd_wb      <= rd_wb_n;
      dmem_addr  <= dmem_addr_n;
      dmem_we    <= dmem_we_n;
      dmem_wdata <= dmem_wdata_n;
      rd_lat     <= rd_lat_n;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt       <= '0;
      mem_fault <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      mem_fault <= mem_fault_n;
    end
  end
`else
  assign mem_fault = 1'b0;
  logic unused_fault;
  assign unused_fault = mem_fault_n;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass, load, store, misaligned, reset-in-WAIT and timeout behaviour.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in, mem_read, mem_write;
  logic [31:0] mem_addr, data_in, dmem_rdata;
  logic [4:0]  rd_mem;
  logic        dmem_ack;
  logic        stall, dmem_req, dmem_we, wb_valid, misalign, mem_fault, state_dbg;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  rd_wb;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .data_in(data_in), .rd_mem(rd_mem),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .rd_wb(rd_wb), .misalign(misalign),
    .mem_fault(mem_fault), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    valid_in  = v;
    mem_read  = r;
    mem_write = w;
    mem_addr  = a;
    data_in   = d;
    rd_mem    = rd;
  endtask

  initial begin
    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // Reset state
    step(); step();
    check("rst_stall", stall, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_rd_wb", rd_wb, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_misalign", misalign, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;

    // Idle with no entry
    step();
    check("idle_wb_valid", wb_valid, 0);

    // ALU pass-through
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    step();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    check("alu_rd_wb", rd_wb, 5);
    check("alu_stall", stall, 0);
    check("alu_req", dmem_req, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check("alu_pulse_end", wb_valid, 0);

    // Load, ack in the third WAIT cycle; inputs wiggle while waiting
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7);
    step();
    check("ld_stall1", stall, 1);
    check("ld_req1", dmem_req, 1);
    check("ld_addr1", dmem_addr, 32'h100);
    check("ld_we1", dmem_we, 0);
    check("ld_wb_valid1", wb_valid, 0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0ABC, 32'h1357_9BDF, 5'd9);
    step();
    check("ld_stall2", stall, 1);
    check("ld_addr2", dmem_addr, 32'h100);
    check("ld_we2", dmem_we, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check("ld_stall3", stall, 1);
    check("ld_req3", dmem_req, 1);
    check("ld_addr3", dmem_addr, 32'h100);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    check("ld_rd_wb", rd_wb, 7);
    check("ld_stall_done", stall, 0);
    check("ld_req_done", dmem_req, 0);

    // Ack while IDLE is ignored
    step();
    check("idle_ack_wb_valid", wb_valid, 0);
    check("idle_ack_stall", stall, 0);
    dmem_ack = 1'b0;

    // Store
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 5'd9);
    step();
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_addr", dmem_addr, 32'h200);
    check("st_wdata", dmem_wdata, 32'hCAFE_0001);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check("st_wdata_hold", dmem_wdata, 32'hCAFE_0001);
    check("st_we_hold", dmem_we, 1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h7777_7777;
    step();
    dmem_ack = 1'b0;
    check("st_wb_valid", wb_valid, 1);
    check("st_rd_wb", rd_wb, 0);
    check("st_wb_data", wb_data, 0);
    check("st_stall_done", stall, 0);

    // Read and write both set: store
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0055, 5'd3);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("rw_we", dmem_we, 1);
    check("rw_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_1111;
    step();
    dmem_ack = 1'b0;
    check("rw_rd_wb", rd_wb, 0);
    check("rw_wb_data", wb_data, 0);

    // Misaligned load
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd4);
    step();
    check("mis_misalign", misalign, 1);
    check("mis_wb_valid", wb_valid, 1);
    check("mis_rd_wb", rd_wb, 0);
    check("mis_wb_data", wb_data, 0);
    check("mis_req", dmem_req, 0);
    check("mis_stall", stall, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check("mis_pulse_end", misalign, 0);
    check("mis_wb_end", wb_valid, 0);
    check("mis_req_after", dmem_req, 0);

    // Reset while waiting, then a late ack
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd2);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("rw_wait_req", dmem_req, 1);
    reset = 1'b0;
    step();
    check("rwait_req", dmem_req, 0);
    check("rwait_stall", stall, 0);
    reset = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h2222_2222;
    step();
    dmem_ack = 1'b0;
    check("rwait_late_ack", wb_valid, 0);
    step();
    check("rwait_late_ack2", wb_valid, 0);

    // Load with no ack: timeout or indefinite wait
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd6);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("to_stall_first", stall, 1);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_stall_wait", stall, 1);
      check("to_fault_early", mem_fault, 0);
    end
    step();
    check("to_fault", mem_fault, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_rd_wb", rd_wb, 0);
    check("to_stall", stall, 0);
    check("to_req", dmem_req, 0);
    step();
    check("to_fault_end", mem_fault, 0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      check("nto_stall", stall, 1);
      check("nto_fault", mem_fault, 0);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h3333_4444;
    step();
    dmem_ack = 1'b0;
    check("nto_wb_data", wb_data, 32'h3333_4444);
    check("nto_rd_wb", rd_wb, 6);
    check("nto_stall_done", stall, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
